// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 byte-write driver: state encoding,
// default timing in 50 MHz clock cycles, and the exec-time classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4,
        DONE  = 3'd5
    } lcdState_t;

    localparam int T_SETUP_DEF      = 4;
    localparam int T_EN_DEF         = 16;
    localparam int T_HOLD_DEF       = 2;
    localparam int T_EXEC_SHORT_DEF = 2500;
    localparam int T_EXEC_LONG_DEF  = 100000;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    function automatic int maxCycles(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/lcd_bus_driver_timer.sv
// Loadable down-counter shared by every timed phase of the LCD driver.
// Counts toward zero and parks there; oZero flags the last cycle of a phase.
module lcd_timer #(
    parameter int W = 18
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iLoad,
    input  logic [W-1:0] iLoadValue,
    output logic         oZero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iLoadValue;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign oZero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: one byte per start edge, with setup, enable
// pulse, hold and command-execution wait generated locally.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP_CYC      = T_SETUP_DEF,
    parameter int T_EN_CYC         = T_EN_DEF,
    parameter int T_HOLD_CYC       = T_HOLD_DEF,
    parameter int T_EXEC_SHORT_CYC = T_EXEC_SHORT_DEF,
    parameter int T_EXEC_LONG_CYC  = T_EXEC_LONG_DEF
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int MAX_CYC = maxCycles(T_SETUP_CYC, T_EN_CYC, T_HOLD_CYC,
                                       T_EXEC_SHORT_CYC, T_EXEC_LONG_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // The timer is loaded with (duration - 1) so a phase lasts exactly its count.
    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(T_EXEC_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(T_EXEC_LONG_CYC - 1);

    lcdState_t        state;
    lcdState_t        nextState;
    logic             startQ;
    logic             accept;
    logic             isLong;
    logic             timerLoad;
    logic [CNT_W-1:0] timerValue;
    logic             timerZero;

    // startQ resets high so a start already asserted at reset release is ignored.
    assign accept = (state == IDLE) && iStart && !startQ;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            startQ   <= 1'b1;
            LCD_DATA <= 8'h00;
            LCD_RS   <= 1'b0;
            isLong   <= 1'b0;
        end else begin
            state  <= nextState;
            startQ <= iStart;
            if (accept) begin
                LCD_DATA <= iDATA;
                LCD_RS   <= iRS;
                isLong   <= is_long_cmd(iRS, iDATA);
            end
        end
    end

    always_comb begin
        nextState  = state;
        timerLoad  = 1'b0;
        timerValue = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState  = SETUP;
                    timerLoad  = 1'b1;
                    timerValue = LOAD_SETUP;
                end
            end
            SETUP: begin
                if (timerZero) begin
                    nextState  = PULSE;
                    timerLoad  = 1'b1;
                    timerValue = LOAD_EN;
                end
            end
            PULSE: begin
                if (timerZero) begin
                    nextState  = HOLD;
                    timerLoad  = 1'b1;
                    timerValue = LOAD_HOLD;
                end
            end
            HOLD: begin
                if (timerZero) begin
                    nextState  = EXEC;
                    timerLoad  = 1'b1;
                    timerValue = isLong ? LOAD_LONG : LOAD_SHORT;
                end
            end
            EXEC: begin
                if (timerZero) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    lcd_timer #(
        .W(CNT_W)
    ) uTimer (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iLoad     (timerLoad),
        .iLoadValue(timerValue),
        .oZero     (timerZero)
    );

    // Strobes decode straight from state so reset drops EN immediately.
    assign LCD_EN = (state == PULSE);
    assign oBusy  = (state != IDLE);
    assign oDone  = (state == DONE);
    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: two instances (default timing with a shortened long
// wait, and a fast 1/1/1/3/5 variant) checked every cycle against a timeline model.
module tb_lcd_bus_driver;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b1;

    logic       start_r [2];
    logic [7:0] data_r  [2];
    logic       rs_r    [2];

    logic       done_w [2];
    logic       busy_w [2];
    logic [7:0] lcd_w  [2];
    logic       rw_w   [2];
    logic       en_w   [2];
    logic       rs_w   [2];

    int checks = 0;
    int errors = 0;
    int n = 0;

    // behavioural model: per instance, the accepting edge and latched request
    bit         m_active [2];
    int         m_acc    [2];
    bit         m_long   [2];
    logic [7:0] m_data   [2];
    logic       m_rs     [2];
    logic       m_prev   [2];

    // observation counters
    int         en_rises  [2];
    int         done_cnt  [2];
    int         en_rise_n [2];
    int         en_fall_n [2];
    int         done_n    [2];
    logic [7:0] rise_data [2];
    logic       prev_en   [2];

    lcd_bus_driver #(
        .T_EXEC_LONG_CYC(10000)
    ) dut0 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(data_r[0]), .iRS(rs_r[0]),
        .iStart(start_r[0]), .oDone(done_w[0]), .oBusy(busy_w[0]),
        .LCD_DATA(lcd_w[0]), .LCD_RW(rw_w[0]), .LCD_EN(en_w[0]), .LCD_RS(rs_w[0])
    );

    lcd_bus_driver #(
        .T_SETUP_CYC(1), .T_EN_CYC(1), .T_HOLD_CYC(1),
        .T_EXEC_SHORT_CYC(3), .T_EXEC_LONG_CYC(5)
    ) dut1 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(data_r[1]), .iRS(rs_r[1]),
        .iStart(start_r[1]), .oDone(done_w[1]), .oBusy(busy_w[1]),
        .LCD_DATA(lcd_w[1]), .LCD_RW(rw_w[1]), .LCD_EN(en_w[1]), .LCD_RS(rs_w[1])
    );

    // ---------------- clock / reset ----------------
    always #10 iCLK = ~iCLK;

    // ---------------- timeline helpers ----------------
    function automatic int setup_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int en_len(input int k);
        return (k == 0) ? 16 : 1;
    endfunction

    function automatic int total_len(input int k, input bit lg);
        if (k == 0) return 4 + 16 + 2 + (lg ? 10000 : 2500);
        return 1 + 1 + 1 + (lg ? 5 : 3);
    endfunction

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model update at each active edge ----------------
    always @(posedge iCLK) begin
        for (int k = 0; k < 2; k++) begin
            if (!iRST_N) begin
                m_active[k] <= 1'b0;
                m_prev[k]   <= 1'b1;
                m_data[k]   <= 8'h00;
                m_rs[k]     <= 1'b0;
                m_long[k]   <= 1'b0;
            end else begin
                if ((!m_active[k] || (n - m_acc[k]) > total_len(k, m_long[k]))
                    && start_r[k] && !m_prev[k]) begin
                    m_active[k] <= 1'b1;
                    m_acc[k]    <= n + 1;
                    m_data[k]   <= data_r[k];
                    m_rs[k]     <= rs_r[k];
                    m_long[k]   <= !rs_r[k] && data_r[k] >= 8'h01 && data_r[k] <= 8'h03;
                end
                m_prev[k] <= start_r[k];
            end
        end
        n <= n + 1;
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge iCLK) begin
        for (int k = 0; k < 2; k++) begin
            int t;
            int d;
            logic [12:0] exp_v;
            logic [12:0] act_v;
            t = n - m_acc[k];
            d = total_len(k, m_long[k]);
            if (!iRST_N) begin
                exp_v = '0;
            end else begin
                exp_v = {m_data[k], m_rs[k], 1'b0,
                         m_active[k] && t >= setup_len(k) && t < setup_len(k) + en_len(k),
                         m_active[k] && t >= 0 && t <= d,
                         m_active[k] && t == d};
            end
            act_v = {lcd_w[k], rs_w[k], rw_w[k], en_w[k], busy_w[k], done_w[k]};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle dut%0d n=%0d {data,rs,rw,en,busy,done}: got %h, expected %h",
                         k, n, act_v, exp_v);
            end
            if (en_w[k] && !prev_en[k]) begin
                en_rises[k]++;
                en_rise_n[k] = n;
                rise_data[k] = lcd_w[k];
            end
            if (!en_w[k] && prev_en[k]) en_fall_n[k] = n;
            if (done_w[k]) begin
                done_cnt[k]++;
                done_n[k] = n;
            end
            prev_en[k] = en_w[k];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int c);
        repeat (c) begin
            @(negedge iCLK);
            #1;
        end
    endtask

    task automatic write_byte(input int k, input logic [7:0] d, input logic r, output int acc);
        data_r[k]  = d;
        rs_r[k]    = r;
        start_r[k] = 1'b1;
        acc        = n + 1;
    endtask

    task automatic wait_done(input int k, input int budget);
        int c0;
        c0 = done_cnt[k];
        for (int i = 0; i < budget && done_cnt[k] == c0; i++) tick(1);
        check_eq("done_arrived", done_cnt[k] - c0, 1);
    endtask

    task automatic wait_en(input int k, input int budget);
        int c0;
        c0 = en_rises[k];
        for (int i = 0; i < budget && en_rises[k] == c0; i++) tick(1);
        check_eq("en_arrived", en_rises[k] - c0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int acc2;
        int e0;
        int d0;
        for (int k = 0; k < 2; k++) begin
            start_r[k] = 1'b0;
            data_r[k]  = 8'h00;
            rs_r[k]    = 1'b0;
            prev_en[k] = 1'b0;
        end
        #1 iRST_N = 1'b0;
        tick(3);
        iRST_N = 1'b1;
        check_eq("reset_busy", busy_w[0], 0);
        check_eq("reset_en", en_w[0], 0);
        check_eq("reset_data", lcd_w[0], 0);
        tick(2);

        // ordinary command: timing of EN and done latency
        write_byte(0, 8'h38, 1'b0, acc);
        wait_done(0, 3000);
        check_eq("short_latency", done_n[0] - acc, 2522);
        check_eq("en_rise_offset", en_rise_n[0] - acc, 4);
        check_eq("en_width", en_fall_n[0] - en_rise_n[0], 16);
        check_eq("bus_at_rise", rise_data[0], 8'h38);
        start_r[0] = 1'b0;
        tick(2);

        // clear display: long wait
        write_byte(0, 8'h01, 1'b0, acc);
        wait_done(0, 11000);
        check_eq("long_latency", done_n[0] - acc, 10022);
        start_r[0] = 1'b0;
        tick(2);

        // same byte as data: short wait
        write_byte(0, 8'h01, 1'b1, acc);
        wait_done(0, 3000);
        check_eq("data01_latency", done_n[0] - acc, 2522);
        start_r[0] = 1'b0;
        tick(2);

        // sequencer style: hold start until done, drop, re-raise 3 cycles later
        e0 = en_rises[0];
        write_byte(0, 8'h06, 1'b0, acc);
        wait_done(0, 3000);
        tick(1);
        start_r[0] = 1'b0;
        tick(3);
        write_byte(0, 8'h57, 1'b1, acc2);
        wait_done(0, 3000);
        check_eq("seq_pulses", en_rises[0] - e0, 2);
        check_eq("seq_bus_second", rise_data[0], 8'h57);
        check_eq("seq_latency2", done_n[0] - acc2, 2522);
        start_r[0] = 1'b0;
        tick(2);

        // start toggled and data changed mid-pulse; start left high past done
        e0 = en_rises[0];
        d0 = done_cnt[0];
        write_byte(0, 8'h28, 1'b0, acc);
        wait_en(0, 20);
        tick(3);
        start_r[0] = 1'b0;
        data_r[0]  = 8'hFF;
        rs_r[0]    = 1'b1;
        tick(1);
        start_r[0] = 1'b1;
        tick(2);
        start_r[0] = 1'b0;
        tick(1);
        start_r[0] = 1'b1;
        wait_done(0, 3000);
        tick(30);
        check_eq("toggle_one_done", done_cnt[0] - d0, 1);
        check_eq("toggle_one_pulse", en_rises[0] - e0, 1);
        check_eq("toggle_data_kept", lcd_w[0], 8'h28);
        check_eq("toggle_rs_kept", rs_w[0], 0);
        check_eq("held_no_retrigger", busy_w[0], 0);
        start_r[0] = 1'b0;
        tick(2);

        // reset mid-pulse with start still high
        write_byte(0, 8'h38, 1'b0, acc);
        wait_en(0, 20);
        tick(4);
        #3 iRST_N = 1'b0;
        #1;
        check_eq("async_en_drop", en_w[0], 0);
        check_eq("async_busy_drop", busy_w[0], 0);
        check_eq("async_data_clear", lcd_w[0], 0);
        tick(3);
        iRST_N = 1'b1;
        e0 = en_rises[0];
        tick(50);
        check_eq("held_at_release_idle", busy_w[0], 0);
        check_eq("held_at_release_no_pulse", en_rises[0] - e0, 0);
        start_r[0] = 1'b0;
        tick(1);
        write_byte(0, 8'h0C, 1'b0, acc);
        wait_done(0, 3000);
        check_eq("after_reset_latency", done_n[0] - acc, 2522);
        start_r[0] = 1'b0;
        tick(2);

        // fast instance: 40 random back-to-back bytes with noisy inputs while busy
        e0 = en_rises[1];
        d0 = done_cnt[1];
        for (int i = 0; i < 40; i++) begin
            int c0;
            logic [7:0] b;
            tick(1 + (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            write_byte(1, b, 1'($urandom_range(0, 1)), acc);
            c0 = done_cnt[1];
            for (int j = 0; j < 40; j++) begin
                tick(1);
                if (done_cnt[1] != c0) break;
                data_r[1]  = 8'($urandom_range(0, 255));
                rs_r[1]    = 1'($urandom_range(0, 1));
                start_r[1] = 1'($urandom_range(0, 1));
            end
            start_r[1] = 1'b0;
        end
        tick(5);
        check_eq("rand_pulse_count", en_rises[1] - e0, 40);
        check_eq("rand_done_count", done_cnt[1] - d0, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Drives the HD44780 character-LCD pins on the DE2-115 for one byte per transaction.
- Sits directly downstream of the LCD init/text sequencer; consumes its byte/RS/start handshake.
- Generates setup, enable-pulse and hold timing, then waits out the command execution time itself.
- Short commands get a short wait; clear/home get a long wait. The sequencer therefore needs no fixed post-write delay.

Parameters:
- T_SETUP_CYC, 4, cycles RS/DATA are stable before EN rises (80 ns @50 MHz)
- T_EN_CYC, 16, cycles EN is high (320 ns)
- T_HOLD_CYC, 2, cycles RS/DATA are held after EN falls
- T_EXEC_SHORT_CYC, 2500, post-write wait for ordinary writes (50 us)
- T_EXEC_LONG_CYC, 100000, post-write wait for clear/home (2 ms)
- All values must be >= 1; counter width = clog2(max of all) + 1

Ports:
- iCLK  in  1  system clock, 50 MHz
- iRST_N  in  1  reset: asynchronous, active-low
- iDATA  in  8  byte to write
- iRS  in  1  0 = command, 1 = data
- iStart  in  1  request, level; accepted on its rising edge
- oDone  out  1  one-cycle pulse when the transaction, including the exec wait, completes
- oBusy  out  1  high in every state except IDLE
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  tied 0 (write-only)
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select

Behaviour:
- Reset (async, active-low):
  - state = IDLE; LCD_DATA = 0, LCD_EN = 0, LCD_RS = 0, LCD_RW = 0, oDone = 0, oBusy = 0; counter = 0.
  - start_q resets to 1, so an iStart already held high at reset release is NOT accepted.
  - Reset during any state drops LCD_EN the moment reset asserts.
- Edge detect: start_q <= iStart every cycle. Accept when state == IDLE && iStart && !start_q.
- On accept: latch iDATA to LCD_DATA and iRS to LCD_RS on that edge. Latch is_long = (iRS == 0 && iDATA in {8'h01, 8'h02, 8'h03}). Go to SETUP.
- States (each occupies exactly its parameter count of cycles, counter counts down):
  - IDLE: EN = 0; LCD_DATA/LCD_RS keep their last value.
  - SETUP (T_SETUP_CYC): EN = 0 -> PULSE.
  - PULSE (T_EN_CYC): EN = 1 -> HOLD.
  - HOLD (T_HOLD_CYC): EN = 0, data held -> EXEC.
  - EXEC (T_EXEC_LONG_CYC if is_long, else T_EXEC_SHORT_CYC) -> DONE.
  - DONE (1 cycle): oDone = 1 -> IDLE.
- Latency: oDone is high in the cycle beginning T_SETUP + T_EN + T_HOLD + T_EXEC clocks after the accepting edge. Defaults: 2522 (short), 100022 (long).
- iDATA/iRS changes after accept are ignored until the next accept.
- Rising edges of iStart while busy (including the DONE cycle) are dropped, not queued.
- iStart held high past oDone does not retrigger; a new write needs iStart low for >= 1 cycle.
- Accept is possible in the cycle right after DONE if iStart rises then.
- Exec-wait classification keys only on the latched byte/RS; 8'h00 with RS = 0 counts as short.

Decomposition:
- Package lcd_pkg:
  - state encoding (IDLE, SETUP, PULSE, HOLD, EXEC, DONE)
  - default timing constants
  - function is_long_cmd(rs, data)
- Sub-module lcd_timer: loadable down-counter with load value, load strobe and zero flag; one instance, reused by every timed state.

Test Plan:
- Reset, then iStart 0->1 with iDATA = 8'h38, iRS = 0 -> LCD_DATA = 8'h38, LCD_RS = 0 next cycle; EN high for exactly 16 cycles beginning 4 cycles after accept; oDone pulse at +2522; oBusy high throughout.
- iDATA = 8'h01, iRS = 0 -> oDone at +100022. Repeat with iRS = 1, 8'h01 -> oDone at +2522.
- Sequencer-style: iStart held high until oDone, dropped next cycle, raised 3 cycles later with 8'h57, RS = 1 -> exactly two EN pulses; bus = 8'h57 during the second pulse.
- iStart toggled and iDATA changed to 8'hFF mid-PULSE -> no second transaction; LCD_DATA stays the original byte; exactly one oDone.
- iRST_N asserted mid-PULSE -> LCD_EN = 0 asynchronously; all outputs at reset values. Release reset with iStart still high -> no transaction until iStart falls and rises again.
- Overrides (1, 1, 1, 3, 5): back-to-back 40 random bytes -> EN pulse count = 40; every setup/pulse/hold/exec duration matches parameters; LCD_RW = 0 always.
